reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_arb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 28 ++
 rtl/reg_bank_arbiter.sv | 91 +++++++++
 tb/tb_reg_bank_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bank arbiter: FSM encoding, requester indices and default sizes.
package reg_arb_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  localparam int REQ_SPI = 0;
  localparam int REQ_SEQ = 1;

  localparam int DEF_NUM_REGS = 5;
  localparam int DEF_ADDR_W   = 7;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant picker producing a one-hot grant.
// Build option REG_ARB_FIXED_PRIO_EN makes requester 0 win every tie instead of alternating.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A lone requester always wins; only a tie consults the history bit.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = 2'b00;
`ifdef REG_ARB_FIXED_PRIO_EN
      grant[REQ_SPI] = 1'b1;
`else
      if (last_grant == 1'b1) begin
        grant[REQ_SPI] = 1'b1;
      end else begin
        grant[REQ_SEQ] = 1'b1;
      end
`endif
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Two-requester write arbiter in front of a small 8-bit register bank.
// Tie policy is round-robin unless REG_ARB_FIXED_PRIO_EN is defined (see rr_arb2).
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [ADDR_W-1:0]     req_addr0,
  input  logic [ADDR_W-1:0]     req_addr1,
  input  logic [7:0]            req_data0,
  input  logic [7:0]            req_data1,
  output logic [1:0]            req_ready,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_pulse,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  err_pulse
);

  // One extra bit keeps the range check from wrapping when NUM_REGS fills the address space.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [0:0]        state;
  logic              last_grant;
  logic [1:0]        grant;
  logic [1:0]        grant_q;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_data;
  logic [7:0]        regs [NUM_REGS];
  logic              in_range;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign in_range = ({1'b0, cap_addr} < ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_q    <= 2'b00;
      cap_addr   <= '0;
      cap_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state      <= WRITE;
            grant_q    <= grant;
            last_grant <= grant[REQ_SEQ];
            cap_addr   <= grant[REQ_SEQ] ? req_addr1 : req_addr0;
            cap_data   <= grant[REQ_SEQ] ? req_data1 : req_data0;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // At most one register matches the captured address, so a write never touches two entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= '0;
      end
    end else if (state == WRITE && in_range) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (cap_addr == ADDR_W'(k)) begin
          regs[k] <= cap_data;
        end
      end
    end
  end

  assign req_ready = (state == WRITE) ? grant_q : 2'b00;
  assign wr_pulse  = (state == WRITE) && in_range;
  assign err_pulse = (state == WRITE) && !in_range;
  assign wr_addr   = cap_addr;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: constant vector table, directed corner sequences and
// randomized traffic against a transaction-level model. Honours REG_ARB_FIXED_PRIO_EN like the design.
module tb_reg_bank_arbiter;

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [ADDR_W-1:0]     req_addr0, req_addr1;
  logic [7:0]            req_data0, req_data1;
  logic [1:0]            req_ready;
  logic [8*NUM_REGS-1:0] regs_out;
  logic                  wr_pulse, err_pulse;
  logic [ADDR_W-1:0]     wr_addr;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] model_regs [NUM_REGS];
  int         model_last;

  typedef struct {
    logic [1:0]        valid;
    logic [ADDR_W-1:0] a0;
    logic [7:0]        d0;
    logic [ADDR_W-1:0] a1;
    logic [7:0]        d1;
    logic [1:0]        exp_ready;
    logic              exp_wr;
    logic              exp_err;
    logic [ADDR_W-1:0] exp_addr;
  } vec_t;

  vec_t vecs [6];

  reg_bank_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr0 (req_addr0),
    .req_addr1 (req_addr1),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .regs_out  (regs_out),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .err_pulse (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [ADDR_W-1:0] a0, input logic [7:0] d0,
                               input logic [ADDR_W-1:0] a1, input logic [7:0] d1);
    req_valid = v;
    req_addr0 = a0;
    req_data0 = d0;
    req_addr1 = a1;
    req_data1 = d1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, want 'h%0h", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    model_last = 1;
  endfunction

  function automatic logic [8*NUM_REGS-1:0] model_flat();
    logic [8*NUM_REGS-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = model_regs[k];
    return f;
  endfunction

  // Who should win given the set of requesters that were pending when the arbiter looked.
  function automatic int pick_winner(input logic [1:0] v);
    if (v == 2'b11) begin
`ifdef REG_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (model_last == 0) ? 1 : 0;
`endif
    end
    return v[1] ? 1 : 0;
  endfunction

  task automatic check_write(input string tag, input int win);
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              ok;
    logic [1:0]        oh;
    a  = (win == 1) ? req_addr1 : req_addr0;
    d  = (win == 1) ? req_data1 : req_data0;
    ok = (int'(a) < NUM_REGS);
    oh = (win == 1) ? 2'b10 : 2'b01;
    checkOutput({tag, ".ready"}, 64'(req_ready), 64'(oh));
    checkOutput({tag, ".wr"},    64'(wr_pulse),  64'(ok));
    checkOutput({tag, ".err"},   64'(err_pulse), 64'(!ok));
    checkOutput({tag, ".addr"},  64'(wr_addr),   64'(a));
    model_last = win;
    if (ok) model_regs[int'(a)] = d;
  endtask

  // Issue one or two simultaneous requests and follow them to completion; served requesters withdraw.
  task automatic run_txn(input string tag, input logic [1:0] v, input logic [ADDR_W-1:0] a0, input logic [7:0] d0,
                         input logic [ADDR_W-1:0] a1, input logic [7:0] d1);
    logic [1:0] pend;
    logic [1:0] sampled;
    int n;
    int win;
    pend = v;
    n    = (v == 2'b11) ? 2 : 1;
    applyStimulus(v, a0, d0, a1, d1);
    for (int c = 1; c <= 2*n; c++) begin
      sampled = req_valid;
      step();
      if (c % 2 == 1) begin
        win = pick_winner(sampled);
        check_write($sformatf("%s.w%0d", tag, c), win);
        pend[win] = 1'b0;
      end else begin
        checkOutput($sformatf("%s.idle%0d", tag, c), 64'(req_ready), 64'(0));
        req_valid = pend;
      end
    end
    checkOutput({tag, ".regs"}, 64'(regs_out), 64'(model_flat()));
  endtask

  task automatic run_vector(input int i);
    vec_t  t;
    int    win;
    string tag;
    t   = vecs[i];
    tag = $sformatf("vec%0d", i);
    applyStimulus(t.valid, t.a0, t.d0, t.a1, t.d1);
    step();
    checkOutput({tag, ".ready"}, 64'(req_ready), 64'(t.exp_ready));
    checkOutput({tag, ".wr"},    64'(wr_pulse),  64'(t.exp_wr));
    checkOutput({tag, ".err"},   64'(err_pulse), 64'(t.exp_err));
    checkOutput({tag, ".addr"},  64'(wr_addr),   64'(t.exp_addr));
    win        = t.exp_ready[1] ? 1 : 0;
    model_last = win;
    if (t.exp_wr) model_regs[int'(t.exp_addr)] = (win == 1) ? t.d1 : t.d0;
    step();
    req_valid = 2'b00;
    checkOutput({tag, ".idle"}, 64'(req_ready), 64'(0));
    checkOutput({tag, ".regs"}, 64'(regs_out),  64'(model_flat()));
  endtask

  // Both requesters keep asking back-to-back; the last one granted drops out near the end.
  task automatic hold_both();
    logic [1:0] sampled;
    int win;
    win = 0;
    applyStimulus(2'b11, 7'd0, 8'h10, 7'd1, 8'h20);
    for (int c = 1; c <= 10; c++) begin
      sampled = req_valid;
      step();
      if (c % 2 == 1) begin
        win = pick_winner(sampled);
        check_write($sformatf("hold.w%0d", c), win);
      end else begin
        checkOutput($sformatf("hold.idle%0d", c), 64'(req_ready), 64'(0));
        if (c == 8)  req_valid[win] = 1'b0;
        if (c == 10) req_valid = 2'b00;
      end
    end
    checkOutput("hold.regs", 64'(regs_out), 64'(model_flat()));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    step();
    step();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 127));
    return ADDR_W'($urandom_range(0, NUM_REGS + 1));
  endfunction

  initial begin
    logic [1:0]        rv;
    logic [ADDR_W-1:0] ra0, ra1;
    logic [7:0]        rd0, rd1;

    vecs[0] = '{2'b01, 7'h00, 8'hA5, 7'h00, 8'h00, 2'b01, 1'b1, 1'b0, 7'h00};
    vecs[1] = '{2'b10, 7'h00, 8'h00, 7'h05, 8'hFF, 2'b10, 1'b0, 1'b1, 7'h05};
    vecs[2] = '{2'b01, 7'h44, 8'h77, 7'h00, 8'h00, 2'b01, 1'b0, 1'b1, 7'h44};
    vecs[3] = '{2'b10, 7'h00, 8'h00, 7'h04, 8'h3C, 2'b10, 1'b1, 1'b0, 7'h04};
    vecs[4] = '{2'b01, 7'h7F, 8'hEE, 7'h00, 8'h00, 2'b01, 1'b0, 1'b1, 7'h7F};
    vecs[5] = '{2'b10, 7'h00, 8'h00, 7'h03, 8'h96, 2'b10, 1'b1, 1'b0, 7'h03};

    rst_n = 1'b0;
    applyStimulus(2'b00, '0, 8'h00, '0, 8'h00);
    model_reset();
    step();
    step();
    checkOutput("rst.regs",  64'(regs_out),  64'(0));
    checkOutput("rst.ready", 64'(req_ready), 64'(0));
    checkOutput("rst.wr",    64'(wr_pulse),  64'(0));
    checkOutput("rst.err",   64'(err_pulse), 64'(0));
    checkOutput("rst.addr",  64'(wr_addr),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) run_vector(i);

    $display("[TB] simultaneous requests");
    run_txn("tie", 2'b11, 7'd1, 8'h11, 7'd2, 8'h22);
    checkOutput("tie.reg1", 64'(regs_out[15:8]),  64'(8'h11));
    checkOutput("tie.reg2", 64'(regs_out[23:16]), 64'(8'h22));

    $display("[TB] continuous contention");
    do_reset();
    hold_both();

    $display("[TB] reset during write");
    applyStimulus(2'b01, 7'd3, 8'h5A, 7'd0, 8'h00);
    step();
    checkOutput("rstwr.ready_pre", 64'(req_ready), 64'(2'b01));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstwr.ready", 64'(req_ready), 64'(0));
    checkOutput("rstwr.wr",    64'(wr_pulse),  64'(0));
    checkOutput("rstwr.regs",  64'(regs_out),  64'(0));
    step();
    req_valid = 2'b00;
    step();
    checkOutput("rstwr.regs_hold", 64'(regs_out), 64'(0));
    checkOutput("rstwr.ready_hold", 64'(req_ready), 64'(0));
    model_reset();
    #2 rst_n = 1'b1;
    run_txn("post_rst", 2'b01, 7'd2, 8'hC3, 7'd0, 8'h00);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      rv  = 2'($urandom_range(1, 3));
      ra0 = rand_addr();
      ra1 = rand_addr();
      rd0 = 8'($urandom_range(0, 255));
      rd1 = 8'($urandom_range(0, 255));
      run_txn($sformatf("rnd%0d", i), rv, ra0, rd0, ra1, rd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
